// File: rtl/dual_issue_sched.sv
// In-order 2-wide issue scheduler: scoreboard for long-latency results plus a busy counter for the divider.
// Dual issue is enabled by defining SCHED_DUAL_ISSUE_EN; otherwise only slot0 ever issues.
module dual_issue_sched #(
    parameter int NREG    = 32,
    parameter int DIV_LAT = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic            stall_i,
    input  logic [1:0]      inst_valid_i,
    input  logic [9:0]      rs1_i,
    input  logic [9:0]      rs2_i,
    input  logic [9:0]      rd_i,
    input  logic [1:0]      rd_we_i,
    input  logic [1:0]      is_mem_i,
    input  logic [1:0]      is_div_i,
    input  logic [1:0]      is_long_i,
    input  logic [1:0]      is_solo_i,
    input  logic [1:0]      wb_valid_i,
    input  logic [9:0]      wb_rd_i,
    output logic [1:0]      issue_o,
    output logic [NREG-1:0] sb_busy_o,
    output logic            div_busy_o
);

    localparam logic [7:0] DIV_LAT_C = 8'(DIV_LAT);

    logic [NREG-1:0] sb_q, sb_d;
    logic [NREG-1:0] wbmask, setmask, eff;
    logic [7:0]      div_cnt_q, div_cnt_d;
    logic            blocked, div_busy;
    logic            ok0, ok1, pair_ok;
    logic            issue0, issue1;
    logic            set0, set1, div_issue;

    logic [4:0] rs1_0, rs2_0, rd_0, rs1_1, rs2_1, rd_1;
    assign rs1_0 = rs1_i[4:0];
    assign rs2_0 = rs2_i[4:0];
    assign rd_0  = rd_i[4:0];
    assign rs1_1 = rs1_i[9:5];
    assign rs2_1 = rs2_i[9:5];
    assign rd_1  = rd_i[9:5];

    function automatic logic hit(input logic [NREG-1:0] v, input logic [4:0] r);
        return (r != 5'd0) && v[r];
    endfunction

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_mask
            localparam logic [4:0] R = 5'(gi);
            assign wbmask[gi]  = (wb_valid_i[0] && wb_rd_i[4:0] == R) ||
                                 (wb_valid_i[1] && wb_rd_i[9:5] == R);
            assign setmask[gi] = (gi != 0) && ((set0 && rd_0 == R) || (set1 && rd_1 == R));
        end
    endgenerate

    // Same-cycle writebacks release dependents; the backend forwards the value.
    assign eff      = sb_q & ~wbmask & ~{{(NREG-1){1'b0}}, 1'b1};
    assign div_busy = (div_cnt_q != 8'd0);
    assign blocked  = rst || flush_i || stall_i;

    assign ok0 = inst_valid_i[0] && !hit(eff, rs1_0) && !hit(eff, rs2_0) &&
                 !(rd_we_i[0] && hit(eff, rd_0)) && !(is_div_i[0] && div_busy);
    assign ok1 = inst_valid_i[1] && !hit(eff, rs1_1) && !hit(eff, rs2_1) &&
                 !(rd_we_i[1] && hit(eff, rd_1)) && !(is_div_i[1] && div_busy);

    assign pair_ok = !(rd_we_i[0] && rd_0 != 5'd0 && (rd_0 == rs1_1 || rd_0 == rs2_1)) &&
                     !(rd_we_i[0] && rd_we_i[1] && rd_0 == rd_1) &&
                     !(&is_mem_i) && !(&is_div_i) && !(|is_solo_i);

    assign issue0 = !blocked && ok0;

`ifdef SCHED_DUAL_ISSUE_EN
    assign issue1 = issue0 && ok1 && pair_ok;
`else
    logic unused_pair;
    assign unused_pair = &{1'b0, ok1, pair_ok};
    assign issue1      = 1'b0;
`endif

    assign issue_o = {issue1, issue0};

    assign set0 = issue0 && is_long_i[0] && rd_we_i[0] && rd_0 != 5'd0;
    assign set1 = issue1 && is_long_i[1] && rd_we_i[1] && rd_1 != 5'd0;
    assign div_issue = (issue0 && is_div_i[0]) || (issue1 && is_div_i[1]);

    always_comb begin
        sb_d      = (sb_q & ~wbmask) | setmask;
        div_cnt_d = div_cnt_q;
        if (flush_i) begin
            sb_d = '0;
        end
        // The divider cannot abort, so flush leaves the counter running.
        if (div_issue) begin
            div_cnt_d = DIV_LAT_C;
        end else if (div_busy) begin
            div_cnt_d = div_cnt_q - 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sb_q      <= '0;
            div_cnt_q <= 8'd0;
        end else begin
            sb_q      <= sb_d;
            div_cnt_q <= div_cnt_d;
        end
    end

    assign sb_busy_o  = sb_q;
    assign div_busy_o = div_busy;

endmodule

// File: tb/tb_dual_issue_sched.sv
// Directed bench for dual_issue_sched: a vector table for single-cycle pairing rules, then hand sequences.
module tb_dual_issue_sched;

`ifdef SCHED_DUAL_ISSUE_EN
    localparam bit DUAL = 1'b1;
`else
    localparam bit DUAL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, flush_i, stall_i;
    logic [1:0]  inst_valid_i, rd_we_i, is_mem_i, is_div_i, is_long_i, is_solo_i, wb_valid_i;
    logic [9:0]  rs1_i, rs2_i, rd_i, wb_rd_i;
    logic [1:0]  issue_o;
    logic [31:0] sb_busy_o;
    logic        div_busy_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dual_issue_sched #(.NREG(32), .DIV_LAT(8)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i), .stall_i(stall_i),
        .inst_valid_i(inst_valid_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i),
        .rd_we_i(rd_we_i), .is_mem_i(is_mem_i), .is_div_i(is_div_i),
        .is_long_i(is_long_i), .is_solo_i(is_solo_i), .wb_valid_i(wb_valid_i),
        .wb_rd_i(wb_rd_i), .issue_o(issue_o), .sb_busy_o(sb_busy_o), .div_busy_o(div_busy_o)
    );

    typedef struct {
        string      name;
        logic [1:0] valid;
        logic [9:0] rs1, rs2, rd;
        logic [1:0] we, mem, solo;
        logic       stall, flush;
        logic [1:0] exp_dual;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic idle();
        flush_i = 0; stall_i = 0; inst_valid_i = 0; rs1_i = 0; rs2_i = 0; rd_i = 0;
        rd_we_i = 0; is_mem_i = 0; is_div_i = 0; is_long_i = 0; is_solo_i = 0;
        wb_valid_i = 0; wb_rd_i = 0;
    endtask

    // Slot0-only instruction; drive at negedge then settle.
    task automatic slot0(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic we, input logic lng, input logic dv);
        @(negedge clk);
        idle();
        inst_valid_i = 2'b01; rs1_i = {5'd0, rs1}; rs2_i = {5'd0, rs2}; rd_i = {5'd0, rd};
        rd_we_i = {1'b0, we}; is_long_i = {1'b0, lng}; is_div_i = {1'b0, dv};
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] exp_of(input logic [1:0] e);
        return DUAL ? e : (e & 2'b01);
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        //              name         valid  rs1          rs2          rd           we     mem    solo   stl fl  exp
        vecs[0]  = '{"indep_alu",    2'b11, {5'd1,5'd1}, {5'd2,5'd2}, {5'd4,5'd3}, 2'b11, 2'b00, 2'b00, 0, 0, 2'b11};
        vecs[1]  = '{"raw_rd7",      2'b11, {5'd7,5'd1}, {5'd2,5'd2}, {5'd4,5'd7}, 2'b11, 2'b00, 2'b00, 0, 0, 2'b01};
        vecs[2]  = '{"both_mem",     2'b11, {5'd1,5'd1}, {5'd2,5'd2}, {5'd4,5'd3}, 2'b11, 2'b11, 2'b00, 0, 0, 2'b01};
        vecs[3]  = '{"solo_s0",      2'b11, {5'd1,5'd1}, {5'd2,5'd2}, {5'd4,5'd3}, 2'b11, 2'b00, 2'b01, 0, 0, 2'b01};
        vecs[4]  = '{"solo_s1",      2'b11, {5'd1,5'd1}, {5'd2,5'd2}, {5'd4,5'd3}, 2'b11, 2'b00, 2'b10, 0, 0, 2'b01};
        vecs[5]  = '{"one_valid",    2'b01, {5'd1,5'd1}, {5'd2,5'd2}, {5'd4,5'd3}, 2'b11, 2'b00, 2'b00, 0, 0, 2'b01};
        vecs[6]  = '{"none_valid",   2'b00, {5'd1,5'd1}, {5'd2,5'd2}, {5'd4,5'd3}, 2'b11, 2'b00, 2'b00, 0, 0, 2'b00};
        vecs[7]  = '{"stall",        2'b11, {5'd1,5'd1}, {5'd2,5'd2}, {5'd4,5'd3}, 2'b11, 2'b00, 2'b00, 1, 0, 2'b00};
        vecs[8]  = '{"raw_r0",       2'b11, {5'd0,5'd1}, {5'd2,5'd2}, {5'd4,5'd0}, 2'b11, 2'b00, 2'b00, 0, 0, 2'b11};
        vecs[9]  = '{"waw_r5",       2'b11, {5'd1,5'd1}, {5'd2,5'd2}, {5'd5,5'd5}, 2'b11, 2'b00, 2'b00, 0, 0, 2'b01};
        vecs[10] = '{"raw_no_we",    2'b11, {5'd1,5'd1}, {5'd7,5'd2}, {5'd4,5'd7}, 2'b10, 2'b00, 2'b00, 0, 0, 2'b11};
        vecs[11] = '{"flush",        2'b11, {5'd1,5'd1}, {5'd2,5'd2}, {5'd4,5'd3}, 2'b11, 2'b00, 2'b00, 0, 1, 2'b00};

        idle();
        rst = 1;
        inst_valid_i = 2'b11; rs1_i = {5'd1, 5'd1}; rd_i = {5'd4, 5'd3}; rd_we_i = 2'b11;
        #1;
        chk("issue_in_reset", 32'(issue_o), 32'd0);
        tick(); tick();
        chk("reset_sb", sb_busy_o, 32'd0);
        chk("reset_div", 32'(div_busy_o), 32'd0);
        @(negedge clk);
        rst = 0;

        // Table: all non-long, non-divide ops, so state stays clear throughout.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            idle();
            inst_valid_i = vecs[i].valid; rs1_i = vecs[i].rs1; rs2_i = vecs[i].rs2;
            rd_i = vecs[i].rd; rd_we_i = vecs[i].we; is_mem_i = vecs[i].mem;
            is_solo_i = vecs[i].solo; stall_i = vecs[i].stall; flush_i = vecs[i].flush;
            #1;
            chk(vecs[i].name, 32'(issue_o), 32'(exp_of(vecs[i].exp_dual)));
        end
        tick();
        chk("sb_after_table", sb_busy_o, 32'd0);

        // Load r5, dependent stalls until writeback of r5.
        slot0(5'd0, 5'd0, 5'd5, 1, 1, 0);
        chk("load_r5_issue", 32'(issue_o), 32'd1);
        tick();
        chk("sb_bit5", sb_busy_o, 32'h20);
        slot0(5'd5, 5'd0, 5'd6, 1, 0, 0);
        chk("dep_r5_blk0", 32'(issue_o), 32'd0);
        tick();
        #1;
        chk("dep_r5_blk1", 32'(issue_o), 32'd0);
        @(negedge clk);
        wb_valid_i = 2'b01; wb_rd_i = {5'd0, 5'd5};
        #1;
        chk("dep_r5_wb", 32'(issue_o), 32'd1);
        tick();
        chk("sb_clr5", sb_busy_o, 32'd0);

        // Set wins over same-cycle writeback of a non-busy register.
        slot0(5'd0, 5'd0, 5'd6, 1, 1, 0);
        wb_valid_i = 2'b10; wb_rd_i = {5'd6, 5'd0};
        #1;
        tick();
        chk("set_wins_r6", sb_busy_o, 32'h40);
        @(negedge clk);
        idle();
        wb_valid_i = 2'b11; wb_rd_i = {5'd6, 5'd6};
        tick();
        chk("dual_wb_same", sb_busy_o, 32'd0);

        // Divider: accepted at E0, busy through E7, second divide issues after E8.
        slot0(5'd1, 5'd2, 5'd0, 0, 0, 1);
        chk("div1_issue", 32'(issue_o), 32'd1);
        tick();
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("div_busy_%0d", k), 32'(div_busy_o), 32'd1);
            slot0(5'd1, 5'd2, 5'd0, 0, 0, 1);
            chk($sformatf("div2_blk_%0d", k), 32'(issue_o), 32'd0);
            tick();
        end
        chk("div_idle", 32'(div_busy_o), 32'd0);
        slot0(5'd1, 5'd2, 5'd0, 0, 0, 1);
        chk("div2_issue", 32'(issue_o), 32'd1);
        tick();
        chk("div2_busy", 32'(div_busy_o), 32'd1);

        // Loads to r5 and r9, WAW block, then flush clears scoreboard but not divider.
        slot0(5'd0, 5'd0, 5'd5, 1, 1, 0);
        tick();
        slot0(5'd0, 5'd0, 5'd9, 1, 1, 0);
        tick();
        chk("sb_5_9", sb_busy_o, 32'h220);
        slot0(5'd0, 5'd0, 5'd5, 1, 0, 0);
        chk("waw_r5_blk", 32'(issue_o), 32'd0);
        slot0(5'd0, 5'd0, 5'd11, 1, 1, 0);
        flush_i = 1;
        #1;
        chk("flush_issue", 32'(issue_o), 32'd0);
        tick();
        chk("flush_sb", sb_busy_o, 32'd0);
        chk("flush_div", 32'(div_busy_o), 32'd1);

        // Reset mid-divide with a busy register.
        slot0(5'd0, 5'd0, 5'd12, 1, 1, 0);
        tick();
        chk("sb_r12", sb_busy_o, 32'h1000);
        @(negedge clk);
        idle();
        rst = 1;
        tick();
        chk("rst_mid_sb", sb_busy_o, 32'd0);
        chk("rst_mid_div", 32'(div_busy_o), 32'd0);
        @(negedge clk);
        rst = 0;
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
